mul_div_unit: RTL
=================

Name: mul_div_unit

Overview:
- Multi-cycle multiply/divide unit with architectural HI/LO registers.
- Successor to the single-cycle ALU: removes mul/div from the combinational ALU path and models realistic, parametrised latency.
- Sits in EX beside the ALU; hazard logic uses the busy flag to stall mult/div/mf/mt instructions.

Parameters:
WIDTH, 32, operand, HI and LO width in bits.
MUL_CYCLES, 5, cycles busy stays high for mult/multu (≥1).
DIV_CYCLES, 10, cycles busy stays high for div/divu (≥1).
CNT_W, 8, countdown counter width; must hold max(MUL_CYCLES, DIV_CYCLES).

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  issue strobe, valid for one cycle; qualifies mdOp
mdOp  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
srcA  input  WIDTH  rs operand (dividend / multiplicand / mthi-mtlo data)
srcB  input  WIDTH  rt operand (divisor / multiplier)
busy  output  1  high while an operation is in flight
hi  output  WIDTH  HI register, driven directly from the flop
lo  output  WIDTH  LO register, driven directly from the flop

Behaviour:
- Reset (synchronous, active-high):
  - hi=0, lo=0, busy=0, counter=0, pending results=0, state=IDLE.
  - Reset mid-operation discards the pending result; HI/LO do not update.
- States: IDLE, RUN.
- IDLE with start=1 and mdOp in 1..4:
  - Latch the op result into pending_hi/pending_lo at this edge.
  - Load counter = MUL_CYCLES (ops 1,2) or DIV_CYCLES (ops 3,4).
  - Go to RUN; busy=1 from the next cycle.
- IDLE with start=1 and mdOp 5/6:
  - hi (5) or lo (6) <= srcA at this edge; busy stays 0.
  - Single-cycle, no RUN.
- IDLE with start=0 or mdOp 0/7: no change.
- RUN:
  - Counter decrements each cycle.
  - On the cycle counter==1: hi<=pending_hi, lo<=pending_lo, busy<=0, next state IDLE.
  - Issue at cycle t gives busy=1 for cycles t+1..t+N; new HI/LO and busy=0 are visible in cycle t+N+1.
- start while busy=1: ignored entirely, including mthi/mtlo. The stall unit guarantees no issue; this behaviour is defined for robustness.
- Arithmetic:
  - mult: signed 2·WIDTH product; hi=upper WIDTH bits, lo=lower WIDTH bits.
  - multu: same as mult, unsigned.
  - div: lo=quotient truncated toward zero; hi=remainder with the dividend's sign.
  - divu: unsigned quotient/remainder.
- Boundary cases:
  - Divide by zero (srcB==0, div or divu): full busy timing still applies; HI/LO keep their prior values at commit.
  - Signed overflow (srcA=most-negative, srcB=-1): lo=most-negative, hi=0.
- hi/lo read combinationally from the flops, so mfhi/mflo read without added latency.
- Back-to-back: a new start is accepted in the first cycle with busy=0, i.e. the same cycle the committed results become visible.

Test Plan:
- mult srcA=0xFFFFFFFE(-2), srcB=3 -> busy high cycles t+1..t+5; at t+6 hi=0xFFFFFFFF, lo=0xFFFFFFFA, busy=0.
- multu srcA=0xFFFFFFFF, srcB=0xFFFFFFFF -> after 5 busy cycles hi=0xFFFFFFFE, lo=0x00000001.
- div srcA=-7 (0xFFFFFFF9), srcB=2 -> after 10 busy cycles lo=0xFFFFFFFD(-3), hi=0xFFFFFFFF(-1). Then divu with the same operands -> lo=0x7FFFFFFC, hi=0x00000001.
- mthi 0x12345678, then mtlo 0xCAFEBABE on the following cycle -> hi/lo update one edge after each, busy never asserts. Then div srcB=0 -> busy 10 cycles, hi/lo unchanged. Then div 0x80000000 by 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Issue mult, then assert start with mdOp=mtlo during busy -> lo is not overwritten by the mtlo and ends as the mult result. Assert reset at busy cycle 3 -> next cycle busy=0, hi=lo=0, and no later commit occurs.
- Parameter sweep with WIDTH=16, MUL_CYCLES=1, DIV_CYCLES=3 -> multu 0xFFFF×0x0002 gives hi=0x0001, lo=0xFFFE after exactly 1 busy cycle; div latency is exactly 3 cycles.

Source files
------------

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// The result is computed at issue and held in pending registers. A countdown
// then models the unit latency, and the result commits to HI/LO when it ends.
module mul_div_unit #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       mdOp,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [CNT_W-1:0]       r_cnt;
  logic [WIDTH-1:0]       r_hi;
  logic [WIDTH-1:0]       r_lo;
  logic [WIDTH-1:0]       r_pend_hi;
  logic [WIDTH-1:0]       r_pend_lo;
  logic                   r_pend_we;
  logic [2*WIDTH-1:0]     w_res;
  logic [CNT_W-1:0]       w_load_cnt;
  logic                   w_div0;
  logic                   w_idle;
  logic                   w_issue;
  logic                   w_mthi;
  logic                   w_mtlo;
  logic                   w_commit;

  // Signed product, returned as {upper, lower} halves.
  function automatic logic [2*WIDTH-1:0] f_mul_s(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
    logic signed [2*WIDTH-1:0] sa;
    logic signed [2*WIDTH-1:0] sb;
    logic signed [2*WIDTH-1:0] p;
    sa = $signed({{WIDTH{a[WIDTH-1]}}, a});
    sb = $signed({{WIDTH{b[WIDTH-1]}}, b});
    p  = sa * sb;
    return p;
  endfunction

  // Unsigned product, returned as {upper, lower} halves.
  function automatic logic [2*WIDTH-1:0] f_mul_u(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
    return {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
  endfunction

  // Signed divide as {remainder, quotient}. The quotient truncates toward zero,
  // and the remainder takes the sign of the dividend. MOST_NEG / -1 saturates
  // to MOST_NEG with a zero remainder. A zero divisor yields a don't-care zero,
  // which the caller never commits.
  function automatic logic [2*WIDTH-1:0] f_div_s(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
    logic signed [WIDTH-1:0] sa;
    logic signed [WIDTH-1:0] sb;
    logic signed [WIDTH-1:0] q;
    logic signed [WIDTH-1:0] r;
    sa = $signed(a);
    sb = $signed(b);
    if (b == '0) begin
      q = '0;
      r = '0;
    end else if (a == MOST_NEG && b == '1) begin
      q = sa;
      r = '0;
    end else begin
      q = sa / sb;
      r = sa % sb;
    end
    return {r, q};
  endfunction

  // Unsigned divide as {remainder, quotient}. The zero-divisor result is unused.
  function automatic logic [2*WIDTH-1:0] f_div_u(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    if (b == '0) begin
      q = '0;
      r = '0;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  assign w_idle   = (r_state == S_IDLE);
  assign w_issue  = start && w_idle && (mdOp >= OP_MULT) && (mdOp <= OP_DIVU);
  assign w_mthi   = start && w_idle && (mdOp == OP_MTHI);
  assign w_mtlo   = start && w_idle && (mdOp == OP_MTLO);
  assign w_commit = (r_state == S_RUN) && (r_cnt == CNT_W'(1));
  assign hi       = r_hi;
  assign lo       = r_lo;

  // Decode the op into its result, its latency and a divide-by-zero flag.
  always_comb begin
    w_res      = '0;
    w_load_cnt = '0;
    w_div0     = 1'b0;
    case (mdOp)
      OP_MULT: begin
        w_res      = f_mul_s(srcA, srcB);
        w_load_cnt = MUL_LOAD;
      end
      OP_MULTU: begin
        w_res      = f_mul_u(srcA, srcB);
        w_load_cnt = MUL_LOAD;
      end
      OP_DIV: begin
        w_res      = f_div_s(srcA, srcB);
        w_load_cnt = DIV_LOAD;
        w_div0     = (srcB == '0);
      end
      OP_DIVU: begin
        w_res      = f_div_u(srcA, srcB);
        w_load_cnt = DIV_LOAD;
        w_div0     = (srcB == '0);
      end
      default: ;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // FSM next-state logic: leave RUN on the last countdown cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_issue)  w_state_nxt = S_RUN;
      S_RUN:   if (w_commit) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: busy covers every RUN cycle.
  always_comb begin
    busy = (r_state == S_RUN);
  end

  // Countdown: load at issue, then step down once per RUN cycle.
  always_ff @(posedge clk) begin
    if (reset)                r_cnt <= '0;
    else if (w_issue)         r_cnt <= w_load_cnt;
    else if (r_state == S_RUN) r_cnt <= r_cnt - CNT_W'(1);
  end

  // Capture the result at issue. A divide by zero marks it as not to be committed.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend_hi <= '0;
      r_pend_lo <= '0;
      r_pend_we <= 1'b0;
    end else if (w_issue) begin
      r_pend_hi <= w_res[2*WIDTH-1:WIDTH];
      r_pend_lo <= w_res[WIDTH-1:0];
      r_pend_we <= !w_div0;
    end
  end

  // Architectural HI/LO: single-cycle moves while idle, or a commit at the end of RUN.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else begin
      if (w_mthi) r_hi <= srcA;
      if (w_mtlo) r_lo <= srcA;
      if (w_commit && r_pend_we) begin
        r_hi <= r_pend_hi;
        r_lo <= r_pend_lo;
      end
    end
  end

endmodule
